pipe_add_sub: RTL and testbench
===============================

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits; legal values 8..64.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth and slice count; WIDTH % STAGES == 0 is required, else elaboration error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset; synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operation presented.
REQ-006 SHALL have port in_ready, output, 1 bit: operation accepted when in_valid && in_ready.
REQ-007 SHALL have port op, input, 2 bits: 0 ADD (A+B), 1 SUB (A-B), 2 INC (A+4), 3 DEC (A-4); B is ignored for INC/DEC.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts when out_valid && out_ready.
REQ-011 SHALL have port result, output, WIDTH bits: sum/difference.
REQ-012 SHALL have port flags, output, 4 bits: {carry, overflow, zero, negative}.

Function
REQ-013 SHALL split operands into STAGES slices of WIDTH/STAGES bits; stage k adds slice k (LSB first) using the carry registered from stage k-1; stage 0 carry-in = 1 for SUB/DEC, else 0.
REQ-014 SHALL form the second operand as b (ADD), ~b (SUB), 4 (INC), ~4 (DEC), zero-extended to WIDTH before inversion.
REQ-015 SHALL delay not-yet-consumed upper operand slices and already-computed lower result slices in per-stage registers so that all slices of one operation emerge together.
REQ-016 SHALL produce a result exactly STAGES cycles after acceptance when out_ready stays high; throughput is one operation per cycle.
REQ-017 SHALL define carry as the final adder carry-out (SUB/DEC: 1 = no borrow), overflow as signed two's-complement overflow, zero as result == 0, and negative as result[WIDTH-1].
REQ-018 SHALL stall the whole pipeline when out_valid && !out_ready; in_ready = !(out_valid && !out_ready); no stage advances and no data is lost or reordered during a stall.
REQ-019 SHALL not collapse bubbles: an empty stage advances as an empty stage.
REQ-020 SHALL hold result and flags stable while out_valid is high and out_ready is low.
REQ-021 SHALL accept a new operation and retire the oldest in the same cycle when out_ready is high.
REQ-022 SHALL support STAGES == 1 as a single registered adder with latency 1.

Reset
REQ-023 SHALL, on rst high at a clock edge, clear all stage valid bits; out_valid, result and flags read 0 from the next cycle.
REQ-024 SHALL discard in-flight operations on reset mid-operation; no stale result may appear after reset.
REQ-025 SHALL hold in_ready at 1 during and after reset.

Configuration
REQ-026 SHALL, with macro PIPE_ADD_SUB_SAT_EN defined, clamp result on signed overflow at the output stage to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow); the overflow flag still reports 1.
REQ-027 SHALL, without PIPE_ADD_SUB_SAT_EN, produce the wrapped (modulo 2^WIDTH) result, with no saturation logic present.

Structure
REQ-028 SHALL place op encodings (OP_ADD, OP_SUB, OP_INC, OP_DEC), the INC/DEC constant 4 and flag bit indices in a shared package, pipe_add_sub_pkg.
REQ-029 SHALL use one sub-module, add_slice: a combinational slice adder with carry-in/carry-out built on the existing 4-bit CLA primitive where the slice width is a multiple of 4.

Verification (WIDTH=32, STAGES=4)
REQ-030 SHALL cover ADD 0xFFFFFFFF + 0x00000001: result 0x00000000, flags carry=1, zero=1, overflow=0; out_valid exactly 4 cycles after acceptance.
REQ-031 SHALL cover SUB 5 - 7: result 0xFFFFFFFE, carry=0, negative=1; DEC 2 gives 0xFFFFFFFE; INC 0xFFFFFFFC gives 0, carry=1.
REQ-032 SHALL cover ADD 0x7FFFFFFF + 1: result 0x80000000, overflow=1; with PIPE_ADD_SUB_SAT_EN the result is 0x7FFFFFFF with overflow=1.
REQ-033 SHALL cover 6 back-to-back ops with out_ready held low for 3 cycles: in_ready drops the cycle out_valid rises, all 6 results arrive in order with no duplicates.
REQ-034 SHALL cover rst asserted 2 cycles after 3 accepted ops: out_valid=0 the next cycle, and no result appears for at least 4 cycles after rst releases.

Source files
------------

// File: rtl/pipe_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings,
// the INC/DEC step constant and bit positions within the flags word.
package pipe_add_sub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_INC = 2'd2,
    OP_DEC = 2'd3
  } op_e;

  localparam int unsigned INC_DEC_CONST = 4;

  localparam int unsigned NUM_FLAGS  = 4;
  localparam int unsigned FLAG_NEG   = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_CARRY = 3;

endpackage

// File: rtl/pipe_add_sub_add_slice.sv
// Combinational slice adder with carry-in/carry-out. Slices whose width is a
// multiple of 4 are built from chained cla4 lookahead blocks; other widths
// fall back to a plain behavioural adder.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c;

endmodule

module add_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  if ((W % 4) == 0) begin : g_cla
    localparam int unsigned N = W / 4;
    logic [N:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_blk
      cla4 u_cla (
        .a    (a[4*i +: 4]),
        .b    (b[4*i +: 4]),
        .cin  (c[i]),
        .sum  (sum[4*i +: 4]),
        .cout (c[i+1])
      );
    end
    assign cout = c[N];
  end else begin : g_ripple
    logic [W:0] full;

    assign full = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    assign sum  = full[W-1:0];
    assign cout = full[W];
  end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/sub/inc/dec unit. Operands are cut into STAGES slices that
// are summed LSB-first, one slice per stage, with the carry registered
// between stages. A stall at the output freezes every stage.
// Optional feature macro: PIPE_ADD_SUB_SAT_EN (signed saturation of the
// final result on overflow; wrapped result when undefined).
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned STG  = (STAGES == 0) ? 1 : STAGES;
  localparam int unsigned SW   = WIDTH / STG;
  localparam int unsigned LAST = STG - 1;

  if (STAGES < 1 || WIDTH < 8 || WIDTH > 64 || (WIDTH % STG) != 0) begin : g_param_check
    $error("pipe_add_sub: WIDTH must be 8..64 and a multiple of STAGES");
  end

  logic             stall;
  logic             advance;
  logic             accept;
  logic             cin0;
  logic [WIDTH-1:0] b_eff;

  // Per-stage adder inputs (from the previous stage register, or the ports)
  logic [WIDTH-1:0] src_a     [STG];
  logic [WIDTH-1:0] src_b     [STG];
  logic [WIDTH-1:0] src_r     [STG];
  logic             src_c     [STG];
  logic             src_v     [STG];
  logic [WIDTH-1:0] nxt_r     [STG];
  logic [SW-1:0]    slice_sum [STG];
  logic             slice_co  [STG];

  // Stage registers; the final stage registers straight into result/flags
  logic [WIDTH-1:0] q_a [STG];
  logic [WIDTH-1:0] q_b [STG];
  logic [WIDTH-1:0] q_r [STG];
  logic             q_c [STG];
  logic             q_v [STG];

  logic [WIDTH-1:0]     raw;
  logic [WIDTH-1:0]     res_final;
  logic                 a_msb;
  logic                 b_msb;
  logic                 ovf;
  logic [NUM_FLAGS-1:0] flags_nxt;

  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign accept   = in_valid && !stall;
  assign in_ready = rst || !stall;

  // Form the second operand and stage-0 carry-in from the op code
  always_comb begin
    b_eff = b;
    cin0  = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        b_eff = b;
        cin0  = 1'b0;
      end
      OP_SUB: begin
        b_eff = ~b;
        cin0  = 1'b1;
      end
      OP_INC: begin
        b_eff = WIDTH'(INC_DEC_CONST);
        cin0  = 1'b0;
      end
      OP_DEC: begin
        b_eff = ~(WIDTH'(INC_DEC_CONST));
        cin0  = 1'b1;
      end
      default: begin
        b_eff = b;
        cin0  = 1'b0;
      end
    endcase
  end

  for (genvar k = 0; k < STG; k++) begin : g_stage
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}}) << (k * SW);

    if (k == 0) begin : g_src_in
      assign src_a[k] = a;
      assign src_b[k] = b_eff;
      assign src_r[k] = '0;
      assign src_c[k] = cin0;
      assign src_v[k] = accept;
    end else begin : g_src_reg
      assign src_a[k] = q_a[k-1];
      assign src_b[k] = q_b[k-1];
      assign src_r[k] = q_r[k-1];
      assign src_c[k] = q_c[k-1];
      assign src_v[k] = q_v[k-1];
    end

    add_slice #(.W(SW)) u_slice (
      .a    (src_a[k][k*SW +: SW]),
      .b    (src_b[k][k*SW +: SW]),
      .cin  (src_c[k]),
      .sum  (slice_sum[k]),
      .cout (slice_co[k])
    );

    // Lower slices already summed ride along; this stage fills in slice k
    assign nxt_r[k] = (src_r[k] & ~SLICE_MASK) | (WIDTH'(slice_sum[k]) << (k * SW));
  end

  // Final-stage flag generation and optional saturation
  always_comb begin
    raw   = nxt_r[LAST];
    a_msb = src_a[LAST][WIDTH-1];
    b_msb = src_b[LAST][WIDTH-1];
    ovf   = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
`ifdef PIPE_ADD_SUB_SAT_EN
    if (ovf) begin
      res_final = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_final = raw;
    end
`else
    res_final = raw;
`endif
    flags_nxt             = '0;
    flags_nxt[FLAG_CARRY] = slice_co[LAST];
    flags_nxt[FLAG_OVF]   = ovf;
    flags_nxt[FLAG_ZERO]  = (res_final == '0);
    flags_nxt[FLAG_NEG]   = res_final[WIDTH-1];
  end

  // Pipeline advance: valid bits always move, payload only loads behind a
  // valid op so bubbles leave the last data (and the zeroed output) untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STG; k++) begin
        q_v[k] <= 1'b0;
        q_c[k] <= 1'b0;
        q_a[k] <= '0;
        q_b[k] <= '0;
        q_r[k] <= '0;
      end
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      for (int unsigned k = 0; k + 1 < STG; k++) begin
        q_v[k] <= src_v[k];
        if (src_v[k]) begin
          q_a[k] <= src_a[k];
          q_b[k] <= src_b[k];
          q_r[k] <= nxt_r[k];
          q_c[k] <= slice_co[k];
        end
      end
      out_valid <= src_v[LAST];
      if (src_v[LAST]) begin
        result <= res_final;
        flags  <= flags_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench for pipe_add_sub (WIDTH=32, STAGES=4). Expected results
// come from a signed/unsigned arithmetic model and are queued on acceptance.
module tb_pipe_add_sub;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  localparam logic [1:0] T_ADD = 2'd0;
  localparam logic [1:0] T_SUB = 2'd1;
  localparam logic [1:0] T_INC = 2'd2;
  localparam logic [1:0] T_DEC = 2'd3;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    int unsigned  cyc;
    bit           lat;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  bit          chk_lat = 0;
  bit          rnd_done = 0;

  pipe_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         m;
    logic [W-1:0] bb;
    logic [W-1:0] r;
    logic [W:0]   u;
    longint       s;
    logic         cy;
    logic         v;
    bit           sub;
    bb  = (o == T_INC || o == T_DEC) ? 32'd4 : y;
    sub = (o == T_SUB || o == T_DEC);
    if (sub) begin
      r  = x - bb;
      cy = (x >= bb);
      s  = longint'($signed(x)) - longint'($signed(bb));
    end else begin
      u  = {1'b0, x} + {1'b0, bb};
      r  = u[W-1:0];
      cy = u[W];
      s  = longint'($signed(x)) + longint'($signed(bb));
    end
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef PIPE_ADD_SUB_SAT_EN
    if (v) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    m.res = r;
    m.flg = {cy, v, (r == 32'd0), r[W-1]};
    m.cyc = cyc;
    m.lat = chk_lat;
    return m;
  endfunction

  // Monitor: retire outputs against the queue head, then enqueue accepted ops
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1 && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("flags", flags, e.flg);
        if (e.lat) check("latency", cyc - e.cyc, S);
      end
    end
    if (rst) q.delete();
    else if (in_valid && in_ready) q.push_back(model(op, a, b));
  end

  task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned n = 0;
    bit acc = 0;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed corner cases plus random ops, output always ready
    chk_lat = 1;
    send(T_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    send(T_SUB, 32'd5, 32'd7);
    send(T_DEC, 32'd2, 32'h1234_5678);
    send(T_INC, 32'hFFFF_FFFC, 32'hAAAA_AAAA);
    send(T_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    send(T_SUB, 32'h8000_0000, 32'h0000_0001);
    send(T_SUB, 32'd7, 32'd7);
    send(T_ADD, 32'h8000_0000, 32'h8000_0000);
    send(T_DEC, 32'h8000_0003, 32'd0);
    for (int i = 0; i < 16; i++) send(2'($urandom_range(0, 3)), $urandom, $urandom);
    drain();

    // Back-to-back ops with output blocked for 3 cycles
    chk_lat = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'(i % 4), 32'h1111_1111 * i, 32'h0F0F_0F0F + i);
      end
      begin
        int unsigned n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("stall_valid_rise", out_valid, 1'b1);
        check("in_ready_drop", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_in_ready", in_ready, 1'b0);
          if (q.size() != 0) begin
            check("hold_result", result, q[0].res);
            check("hold_flags", flags, q[0].flg);
          end
          if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with ops in flight
    chk_lat = 1;
    send(T_ADD, 32'd10, 32'd20);
    send(T_SUB, 32'd100, 32'd1);
    send(T_INC, 32'd9, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_result", result, 0);
    end
    check("post_rst_queue", q.size(), 0);
    @(posedge clk); #1;

    // Random ops under random output backpressure
    chk_lat = 0;
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(2'($urandom_range(0, 3)), $urandom, $urandom);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
